preg_bank: RTL and testbench
============================

# preg_bank

Parametrised pointer register bank for the OSECPU core: a successor to the fixed 64-entry, two-read pointer file. Each entry holds a label ID (LBID), an offset (OFS) and a valid bit. The bank provides two combinational read ports and one write port with load or offset-add (pointer arithmetic) modes. A walking clear engine initialises or bulk-invalidates the bank after reset or on request.

## Interface
- ADDR_W, default 6: entry index width; depth = 2^ADDR_W.
- LBID_W, default 12: label ID width.
- OFS_W, default 16: offset width; the add delta has the same width.

- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear_req  in  1  start a bulk invalidate; sampled only in IDLE.
- ready  out  1  high in IDLE; low while clearing.
- p0, p1  in  ADDR_W  read indices.
- lbid0, lbid1  out  LBID_W  read label IDs.
- ofs0, ofs1  out  OFS_W  read offsets.
- vld0, vld1  out  1  entry valid.
- we  in  1  write request.
- wmode  in  1  0 = load, 1 = add delta to offset.
- pw  in  ADDR_W  write index.
- lbidw  in  LBID_W  load label ID; ignored in add mode.
- ofsw  in  OFS_W  load offset, or two's-complement delta in add mode.
- err  out  1  registered one-cycle pulse on a rejected write.

## Operation
- Storage is per-entry {valid, lbid, ofs} in an array with no reset. Only the control flops are reset.
- FSM states: CLEAR and IDLE.
- On reset: state = CLEAR, clear index = 0, ready = 0, err = 0.
- CLEAR: each cycle writes {0,0,0} to entry[idx] and increments idx. On the cycle that writes idx = 2^ADDR_W−1, the next state is IDLE.
- IDLE + clear_req: next state is CLEAR with idx = 0. An accepted write in that same cycle still commits first.
- Reads are combinational. While ready = 0, all read outputs are forced to 0. In IDLE, read outputs show the stored entry; lbid and ofs are forced to 0 whenever that entry's valid bit is 0.
- Load (we = 1, wmode = 0, IDLE): entry[pw] ← {1, lbidw, ofsw}.
- Add (we = 1, wmode = 1, IDLE, entry[pw] valid): ofs ← (ofs + ofsw) mod 2^OFS_W. LBID and valid are unchanged.
- Rejected writes pulse err on the next cycle and do not change the entry:
  - add to an invalid entry;
  - any write while in CLEAR.
- p0 = p1 is legal; both ports return identical data.

## Timing
- Read latency is 0 cycles (combinational from p0/p1 and array contents).
- A write commits at the rising edge where we = 1 and is visible on reads in the following cycle. The macro below changes this.
- Clear takes exactly 2^ADDR_W cycles; ready rises in the cycle after the last entry is written.
- With ADDR_W = 6, after reset deassertion ready is 0 for 64 rising edges and 1 from the 65th cycle onward.
- Reset asserted mid-clear or mid-operation immediately drops ready and err. The walk restarts from index 0 when reset deasserts.
- err is asserted for exactly one cycle per rejected write. Back-to-back rejected writes give a continuous high.

## Configuration
- PREG_FWD_EN defined: a read port whose index equals pw during an accepted write returns the new entry value combinationally in the same cycle. In add mode this is the post-add offset. Rejected writes are not forwarded.
- PREG_FWD_EN undefined: reads return pre-write contents until the edge, with no forwarding mux.

## Test plan
- Reset, then hold idle → ready = 0 for 64 cycles then 1. Reading every index gives vld = 0, lbid = 0, ofs = 0 (no X).
- Load pw = 5, lbidw = 0x123, ofsw = 0x0010; next cycle p0 = p1 = 5 → lbid = 0x123, ofs = 0x0010, vld = 1 on both ports.
- Add 0xFFF8 (−8) to entry 5, then add 0xFFF0 to an entry holding 0x0008 → ofs = 0x0008 after the first add, then 0xFFF8 (wrap). LBID unchanged.
- Add to invalid entry 9, and load during CLEAR → err high for one cycle each. Entry 9 stays invalid and the clear walk is unaffected.
- With entries loaded, pulse clear_req in IDLE → ready low for 64 cycles, then all entries invalid. Assert reset at cycle 20 of the walk → walk restarts and ready rises 64 cycles after reset deasserts.
- PREG_FWD_EN: load pw = 3 while p0 = 3 → same-cycle lbid0/ofs0 equal the written values. Without the macro, the old values appear until the next cycle.

Source files
------------

// File: rtl/preg_bank.sv
// Pointer register bank: {valid, lbid, ofs} entries, two combinational read ports, one load/add write port.
// Latency: reads 0 cycles; writes visible the cycle after commit (same cycle with PREG_FWD_EN); err 1 cycle.
// Backpressure: ready low during the 2^ADDR_W-cycle clear walk; writes then are rejected with err.
module preg_bank #(
    parameter int ADDR_W = 6,
    parameter int LBID_W = 12,
    parameter int OFS_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    output logic              ready,
    input  logic [ADDR_W-1:0] p0,
    input  logic [ADDR_W-1:0] p1,
    output logic [LBID_W-1:0] lbid0,
    output logic [LBID_W-1:0] lbid1,
    output logic [OFS_W-1:0]  ofs0,
    output logic [OFS_W-1:0]  ofs1,
    output logic              vld0,
    output logic              vld1,
    input  logic              we,
    input  logic              wmode,
    input  logic [ADDR_W-1:0] pw,
    input  logic [LBID_W-1:0] lbidw,
    input  logic [OFS_W-1:0]  ofsw,
    output logic              err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef struct packed {
        logic              vld;
        logic [LBID_W-1:0] lbid;
        logic [OFS_W-1:0]  ofs;
    } entry_t;

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;
    entry_t            mem [DEPTH];
    entry_t            cur_w, new_w, rd0, rd1;
    logic              wr_acc, wr_rej;

    // Hidden entries (invalid, or bank not ready) read as all-zero.
    function automatic entry_t mask(input entry_t e, input logic rdy);
        if (!rdy || !e.vld) return '0;
        return e;
    endfunction

    assign ready = (state == S_IDLE);

    always_comb begin
        cur_w  = mem[pw];
        wr_acc = 1'b0;
        wr_rej = 1'b0;
        if (we) begin
            if (state != S_IDLE || (wmode && !cur_w.vld)) wr_rej = 1'b1;
            else                                         wr_acc = 1'b1;
        end
        new_w = cur_w;
        if (wmode) new_w.ofs = cur_w.ofs + ofsw;
        else       new_w     = {1'b1, lbidw, ofsw};
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            S_CLEAR: begin
                idx_nxt = idx + 1'b1;
                if (idx == LAST) state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (clear_req) begin
                    state_nxt = S_CLEAR;
                    idx_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_CLEAR;
                idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_CLEAR;
            idx   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            err   <= wr_rej;
        end
    end

    // Storage carries no reset; the clear walk is what initialises it.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR)
            mem[idx] <= '0;
        else if (wr_acc)
            mem[pw] <= new_w;
    end

    always_comb begin
        rd0 = mem[p0];
        rd1 = mem[p1];
`ifdef PREG_FWD_EN
        if (wr_acc && p0 == pw) rd0 = new_w;
        if (wr_acc && p1 == pw) rd1 = new_w;
`endif
        {vld0, lbid0, ofs0} = mask(rd0, ready);
        {vld1, lbid1, ofs1} = mask(rd1, ready);
    end

endmodule

// File: tb/tb_preg_bank.sv
// Randomized + directed bench for preg_bank against an abstract entry/clear-countdown model.
module tb_preg_bank;
    localparam int AW = 6, LW = 12, OW = 16, DEPTH = 64;

    logic          clk = 1'b0;
    logic          reset, clear_req, we, wmode;
    logic [AW-1:0] p0, p1, pw;
    logic [LW-1:0] lbidw, lbid0, lbid1;
    logic [OW-1:0] ofsw, ofs0, ofs1;
    logic          vld0, vld1, ready, err;

    preg_bank #(.ADDR_W(AW), .LBID_W(LW), .OFS_W(OW)) dut (
        .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready),
        .p0(p0), .p1(p1), .lbid0(lbid0), .lbid1(lbid1), .ofs0(ofs0), .ofs1(ofs1),
        .vld0(vld0), .vld1(vld1), .we(we), .wmode(wmode), .pw(pw),
        .lbidw(lbidw), .ofsw(ofsw), .err(err)
    );

    always #5 clk = ~clk;

    // Model: entry contents plus number of clear cycles still to run (0 = ready).
    bit            m_vld  [DEPTH];
    logic [LW-1:0] m_lbid [DEPTH];
    logic [OW-1:0] m_ofs  [DEPTH];
    int            m_left;
    bit            m_err;
    int            checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_wipe();
        for (int i = 0; i < DEPTH; i++) begin
            m_vld[i] = 0; m_lbid[i] = '0; m_ofs[i] = '0;
        end
    endtask

    function automatic bit m_accept();
        return (m_left == 0) && we && !(wmode && !m_vld[pw]);
    endfunction

    task automatic exp_port(input logic [AW-1:0] p, output logic v,
                            output logic [LW-1:0] l, output logic [OW-1:0] o);
        v = 0; l = '0; o = '0;
        if (m_left == 0) begin
            v = m_vld[p]; l = m_lbid[p]; o = m_ofs[p];
`ifdef PREG_FWD_EN
            if (m_accept() && p == pw) begin
                v = 1;
                l = wmode ? m_lbid[p] : lbidw;
                o = wmode ? OW'(m_ofs[p] + ofsw) : ofsw;
            end
`endif
            if (!v) begin l = '0; o = '0; end
        end
    endtask

    task automatic check_all(input string tag);
        logic v; logic [LW-1:0] l; logic [OW-1:0] o;
        chk({tag, ".ready"}, ready, (m_left == 0));
        chk({tag, ".err"}, err, m_err);
        exp_port(p0, v, l, o);
        chk({tag, ".vld0"}, vld0, v); chk({tag, ".lbid0"}, lbid0, l); chk({tag, ".ofs0"}, ofs0, o);
        exp_port(p1, v, l, o);
        chk({tag, ".vld1"}, vld1, v); chk({tag, ".lbid1"}, lbid1, l); chk({tag, ".ofs1"}, ofs1, o);
    endtask

    // One rising edge; model advances with the inputs that were applied before it.
    task automatic tick();
        bit nerr, acc, start;
        logic [AW-1:0] a_pw; logic [LW-1:0] a_l; logic [OW-1:0] a_o; bit a_mode;
        nerr  = we && (m_left != 0 || (wmode && !m_vld[pw]));
        acc   = m_accept();
        start = (m_left == 0) && clear_req;
        a_pw = pw; a_l = lbidw; a_o = ofsw; a_mode = wmode;
        @(posedge clk); #1;
        if (acc) begin
            if (a_mode) m_ofs[a_pw] = m_ofs[a_pw] + a_o;
            else begin m_vld[a_pw] = 1; m_lbid[a_pw] = a_l; m_ofs[a_pw] = a_o; end
        end
        if (m_left > 0) m_left--;
        else if (start) begin m_left = DEPTH; m_wipe(); end
        m_err = nerr;
    endtask

    task automatic idle_in();
        we = 0; wmode = 0; clear_req = 0; pw = '0; lbidw = '0; ofsw = '0;
    endtask

    task automatic wr(input bit mode, input int idx, input int l, input int o);
        we = 1; wmode = mode; pw = AW'(idx); lbidw = LW'(l); ofsw = OW'(o);
    endtask

    task automatic rnd_in(input int we_pct, input int clr_pct);
        pw    = AW'($urandom_range(0, 15));
        we    = ($urandom_range(0, 99) < we_pct);
        wmode = $urandom_range(0, 1) == 1;
        lbidw = LW'($urandom);
        ofsw  = OW'($urandom);
        clear_req = ($urandom_range(0, 99) < clr_pct);
        p0 = ($urandom_range(0, 3) == 0) ? pw : AW'($urandom_range(0, 15));
        p1 = ($urandom_range(0, 3) == 0) ? p0 : AW'($urandom_range(0, 63));
    endtask

    // Asynchronous reset applied between edges; outputs must drop at once.
    task automatic do_reset(input string tag);
        reset = 1;
        m_left = DEPTH; m_err = 0; m_wipe();
        #1;
        chk({tag, ".ready_async"}, ready, 1'b0);
        chk({tag, ".err_async"}, err, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        #1;
    endtask

    task automatic walk(input string tag, input int we_pct);
        for (int i = 0; i < DEPTH; i++) begin
            rnd_in(we_pct, 20);
            #1 check_all(tag);
            tick();
        end
        idle_in();
        #1 check_all({tag, ".done"});
        chk({tag, ".ready_after"}, ready, 1'b1);
    endtask

    initial begin
        idle_in(); p0 = '0; p1 = '0; reset = 1;
        m_left = DEPTH; m_err = 0; m_wipe();
        #2;
        do_reset("por");
        walk("clr0", 30);

        for (int i = 0; i < DEPTH; i++) begin
            p0 = AW'(i); p1 = AW'(DEPTH - 1 - i);
            #1 check_all("sweep0");
            tick();
        end

        // Load / add directed cases with spec-derived constants.
        wr(0, 5, 'h123, 'h0010); p0 = 5; p1 = 5; tick(); idle_in();
        #1 check_all("ld5");
        chk("ld5.lbid_const", lbid1, 12'h123); chk("ld5.ofs_const", ofs0, 16'h0010);
        chk("ld5.vld_const", {vld0, vld1}, 2'b11);
        wr(1, 5, 'hFFF, 'hFFF8); tick(); idle_in();
        #1 chk("add5.ofs", ofs0, 16'h0008); chk("add5.lbid", lbid0, 12'h123);
        wr(0, 7, 'h0AB, 'h0008); tick(); wr(1, 7, 0, 'hFFF0); p0 = 7; tick(); idle_in();
        #1 chk("add7.wrap", ofs0, 16'hFFF8); chk("add7.lbid", lbid0, 12'h0AB);
        check_all("add7");
        wr(1, 9, 0, 1); p1 = 9; tick(); idle_in();
        #1 chk("inv9.err", err, 1'b1); check_all("inv9");
        tick();
        #1 chk("inv9.err_clr", err, 1'b0); chk("inv9.vld", vld1, 1'b0);
        wr(1, 9, 0, 1); tick(); tick(); idle_in();
        #1 chk("b2b.err", err, 1'b1);
        tick();

        // Same-cycle visibility of a load depends on forwarding.
        wr(0, 3, 'h111, 'h2222); tick();
        wr(0, 3, 'h456, 'h789A); p0 = 3;
        #1 check_all("fwd");
`ifdef PREG_FWD_EN
        chk("fwd.lbid_same", lbid0, 12'h456); chk("fwd.ofs_same", ofs0, 16'h789A);
`else
        chk("fwd.lbid_same", lbid0, 12'h111); chk("fwd.ofs_same", ofs0, 16'h2222);
`endif
        tick(); idle_in();
        #1 chk("fwd.lbid_next", lbid0, 12'h456);

        for (int i = 0; i < 500; i++) begin
            rnd_in(70, 1);
            #1 check_all("rnd");
            tick();
        end
        idle_in();
        for (int i = 0; i < 2 * DEPTH && m_left != 0; i++) tick();

        wr(0, 12, 'h321, 'h4444); tick(); idle_in();
        clear_req = 1; tick(); clear_req = 0;
        walk("clr1", 20);
        for (int i = 0; i < 16; i++) begin
            p0 = AW'(i); p1 = AW'(i);
            #1 check_all("sweep1");
        end

        // Reset in the middle of a walk, just after a rejected write.
        wr(0, 2, 'h1, 'h1); tick(); idle_in();
        clear_req = 1; tick(); clear_req = 0;
        for (int i = 0; i < 19; i++) begin
            rnd_in(10, 50);
            #1 check_all("mid");
            tick();
        end
        wr(0, 4, 'h5, 'h6); tick(); idle_in();
        #1 chk("mid.err_before_rst", err, 1'b1);
        do_reset("midrst");
        walk("clr2", 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
